// File: rtl/ctrl_decode_stage_pkg.sv
// Shared constants and types for the ID/EX control decode stage.
// Zbb legality helpers are used only when ZBB_DECODE_EN is defined.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [6:0] F7_MINMAX = 7'b0000101;
  localparam logic [6:0] F7_ROT    = 7'b0110000;
  localparam logic [6:0] F7_ZEXT   = 7'b0000100;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_BR  = 2'b01;
  localparam logic [1:0] ALU_OP_R   = 2'b10;
  localparam logic [1:0] ALU_OP_I   = 2'b11;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_SB   = 2'b01;
  localparam logic [1:0] WE_SH   = 2'b10;
  localparam logic [1:0] WE_SW   = 2'b11;

  typedef enum logic {S_RUN = 1'b0, S_WAIT = 1'b1} state_t;

  typedef struct packed {
    logic       mem_to_reg;
    logic [1:0] data_mem_we;
    logic       rd_we;
    logic       alu_src_b;
    logic       branch;
    logic [1:0] alu_op;
    logic       rs1_use;
    logic       rs2_use;
    logic       pc_op;
    logic       muldiv;
    logic       zbb;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP     = ctrl_t'(14'b00000000000000);
  localparam ctrl_t CTRL_ILLEGAL = ctrl_t'(14'b00000000000001);

  function automatic logic zbb_r_legal(input logic [2:0] f3, input logic [6:0] f7);
    return ((f7 == F7_ALT) & ((f3 == 3'b111) | (f3 == 3'b110) | (f3 == 3'b100))) |
           (f7 == F7_MINMAX) |
           ((f7 == F7_ROT) & ((f3 == 3'b001) | (f3 == 3'b101))) |
           ((f7 == F7_ZEXT) & (f3 == 3'b100));
  endfunction

  function automatic logic zbb_i_legal(input logic [2:0] f3, input logic [6:0] f7);
    return (f7 == F7_ROT) & ((f3 == 3'b001) | (f3 == 3'b101));
  endfunction

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// Handshake and control-word bundle between ID, the decode stage and EX.
interface ctrl_decode_stage_if;
  logic       instr_valid_i;
  logic       instr_ready_o;
  logic [6:0] opcode_i;
  logic [2:0] funct3_i;
  logic [6:0] funct7_i;
  logic       stall_i;
  logic       flush_i;
  logic       ex_valid_o;
  logic       mem_to_reg_o;
  logic [1:0] data_mem_we_o;
  logic       rd_we_o;
  logic       alu_src_b_o;
  logic       branch_o;
  logic [1:0] alu_2bit_op_o;
  logic       rs1_in_use_o;
  logic       rs2_in_use_o;
  logic       pc_operand_o;
  logic       muldiv_o;
  logic       zbb_o;
  logic       illegal_o;
  logic       busy_o;

  modport master (
    output instr_valid_i, opcode_i, funct3_i, funct7_i, stall_i, flush_i,
    input  instr_ready_o, ex_valid_o, mem_to_reg_o, data_mem_we_o, rd_we_o,
           alu_src_b_o, branch_o, alu_2bit_op_o, rs1_in_use_o, rs2_in_use_o,
           pc_operand_o, muldiv_o, zbb_o, illegal_o, busy_o
  );

  modport slave (
    input  instr_valid_i, opcode_i, funct3_i, funct7_i, stall_i, flush_i,
    output instr_ready_o, ex_valid_o, mem_to_reg_o, data_mem_we_o, rd_we_o,
           alu_src_b_o, branch_o, alu_2bit_op_o, rs1_in_use_o, rs2_in_use_o,
           pc_operand_o, muldiv_o, zbb_o, illegal_o, busy_o
  );
endinterface

// File: rtl/ctrl_decode_stage_comb.sv
// Combinational RV32IM control decode and legality check.
// Zbb combinations are recognised only when ZBB_DECODE_EN is defined.
module ctrl_decode_comb
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output ctrl_t      o_ctrl
);

  logic  w_zbb_r;
  logic  w_zbb_i;
  logic  w_r_base_legal;
  ctrl_t w_raw;

`ifdef ZBB_DECODE_EN
  assign w_zbb_r = zbb_r_legal(i_funct3, i_funct7);
  assign w_zbb_i = zbb_i_legal(i_funct3, i_funct7);
`else
  assign w_zbb_r = 1'b0;
  assign w_zbb_i = 1'b0;
`endif

  assign w_r_base_legal = (i_funct7 == F7_BASE) |
                          ((i_funct7 == F7_ALT) & ((i_funct3 == 3'b000) | (i_funct3 == 3'b101)));

  // Per-opcode control fields before the illegal-word override
  always_comb begin
    w_raw = CTRL_NOP;
    case (i_opcode)
      OP_R: begin
        w_raw.rd_we   = 1'b1;
        w_raw.alu_op  = ALU_OP_R;
        w_raw.rs1_use = 1'b1;
        w_raw.rs2_use = 1'b1;
        w_raw.muldiv  = (i_funct7 == F7_MULDIV);
        w_raw.zbb     = w_zbb_r;
        w_raw.illegal = ~(w_r_base_legal | (i_funct7 == F7_MULDIV) | w_zbb_r);
      end
      OP_IMM: begin
        w_raw.rd_we     = 1'b1;
        w_raw.alu_src_b = 1'b1;
        w_raw.alu_op    = ALU_OP_I;
        w_raw.rs1_use   = 1'b1;
        w_raw.zbb       = w_zbb_i;
        w_raw.illegal   = zbb_i_legal(i_funct3, i_funct7) & ~w_zbb_i;
      end
      OP_LOAD: begin
        w_raw.mem_to_reg = 1'b1;
        w_raw.rd_we      = 1'b1;
        w_raw.alu_src_b  = 1'b1;
        w_raw.alu_op     = ALU_OP_ADD;
        w_raw.rs1_use    = 1'b1;
      end
      OP_BRANCH: begin
        w_raw.branch    = 1'b1;
        w_raw.alu_src_b = 1'b1;
        w_raw.alu_op    = ALU_OP_BR;
        w_raw.rs1_use   = 1'b1;
        w_raw.rs2_use   = 1'b1;
      end
      OP_STORE: begin
        w_raw.alu_src_b = 1'b1;
        w_raw.alu_op    = ALU_OP_ADD;
        w_raw.rs1_use   = 1'b1;
        w_raw.rs2_use   = 1'b1;
        case (i_funct3)
          3'b000:  w_raw.data_mem_we = WE_SB;
          3'b001:  w_raw.data_mem_we = WE_SH;
          3'b010:  w_raw.data_mem_we = WE_SW;
          default: w_raw.illegal     = 1'b1;
        endcase
      end
      OP_JALR: begin
        w_raw.rd_we     = 1'b1;
        w_raw.alu_src_b = 1'b1;
        w_raw.branch    = 1'b1;
        w_raw.pc_op     = 1'b1;
        w_raw.rs1_use   = 1'b1;
      end
      OP_AUIPC: begin
        w_raw.rd_we     = 1'b1;
        w_raw.alu_src_b = 1'b1;
        w_raw.pc_op     = 1'b1;
      end
      OP_LUI: begin
        w_raw.rd_we     = 1'b1;
        w_raw.alu_src_b = 1'b1;
      end
      default: w_raw.illegal = 1'b1;
    endcase
  end

  // An illegal word must never write registers, memory or redirect the PC
  assign o_ctrl = w_raw.illegal ? CTRL_ILLEGAL : w_raw;

endmodule

// File: rtl/ctrl_decode_stage.sv
// ID/EX control register with valid/ready handshake, stall, flush and mul/div throttle.
// Optional Zbb decode is enabled by defining ZBB_DECODE_EN.
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33
) (
  input  logic                clk,
  input  logic                reset,
  ctrl_decode_stage_if.slave  bus
);

  localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

  ctrl_t      w_dec;
  ctrl_t      r_ctrl;
  ctrl_t      w_ctrl_nxt;
  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_ex_valid;
  logic       w_ex_valid_nxt;
  logic       r_busy;
  logic       w_busy_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       w_ready;
  logic       w_accept;

  ctrl_decode_comb u_dec (
    .i_opcode (bus.opcode_i),
    .i_funct3 (bus.funct3_i),
    .i_funct7 (bus.funct7_i),
    .o_ctrl   (w_dec)
  );

  assign w_ready  = (r_state == S_RUN) & (~r_ex_valid | ~bus.stall_i);
  assign w_accept = bus.instr_valid_i & w_ready;

  // Next-state, control word, valid and countdown; flush overrides everything
  always_comb begin
    w_state_nxt    = r_state;
    w_ctrl_nxt     = r_ctrl;
    w_ex_valid_nxt = r_ex_valid;
    w_busy_nxt     = r_busy;
    w_cnt_nxt      = r_cnt;
    if (bus.flush_i) begin
      w_state_nxt    = S_RUN;
      w_ex_valid_nxt = 1'b0;
      w_busy_nxt     = 1'b0;
      w_cnt_nxt      = 8'd0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_accept) begin
            w_ctrl_nxt = w_dec;
            if (w_dec.muldiv) begin
              w_ex_valid_nxt = 1'b0;
              w_busy_nxt     = 1'b1;
              w_cnt_nxt      = bus.funct3_i[2] ? DIV_LOAD : MUL_LOAD;
              w_state_nxt    = S_WAIT;
            end else begin
              w_ex_valid_nxt = 1'b1;
            end
          end else if (r_ex_valid & bus.stall_i) begin
            w_ex_valid_nxt = 1'b1;
          end else begin
            w_ex_valid_nxt = 1'b0;
          end
        end
        S_WAIT: begin
          if (r_cnt == 8'd0) begin
            w_ex_valid_nxt = 1'b1;
            w_busy_nxt     = 1'b0;
            w_state_nxt    = S_RUN;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
        default: begin
          w_state_nxt = S_RUN;
        end
      endcase
    end
  end

  // State and ID/EX control register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_RUN;
      r_ctrl     <= CTRL_NOP;
      r_ex_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_cnt      <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_ctrl     <= w_ctrl_nxt;
      r_ex_valid <= w_ex_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign bus.instr_ready_o = w_ready;
  assign bus.ex_valid_o    = r_ex_valid;
  assign bus.busy_o        = r_busy;
  assign bus.mem_to_reg_o  = r_ctrl.mem_to_reg;
  assign bus.data_mem_we_o = r_ctrl.data_mem_we;
  assign bus.rd_we_o       = r_ctrl.rd_we;
  assign bus.alu_src_b_o   = r_ctrl.alu_src_b;
  assign bus.branch_o      = r_ctrl.branch;
  assign bus.alu_2bit_op_o = r_ctrl.alu_op;
  assign bus.rs1_in_use_o  = r_ctrl.rs1_use;
  assign bus.rs2_in_use_o  = r_ctrl.rs2_use;
  assign bus.pc_operand_o  = r_ctrl.pc_op;
  assign bus.muldiv_o      = r_ctrl.muldiv;
  assign bus.zbb_o         = r_ctrl.zbb;
  assign bus.illegal_o     = r_ctrl.illegal;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage: stimulus pushes expected control words,
// a monitor pops one each time EX takes a word (ex_valid_o & ~stall_i).
module tb_ctrl_decode_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [13:0] exp_q[$];
  logic [13:0] mon_exp;
  int   edges;
  int   busy_n;
  logic rdy_seen;

  ctrl_decode_stage_if bus();

  ctrl_decode_stage #(.MUL_CYCLES(2), .DIV_CYCLES(33)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Field order: mem_to_reg, we[1:0], rd_we, src_b, branch, op[1:0], rs1, rs2, pc_op, muldiv, zbb, illegal
  function automatic logic [13:0] cw(input logic m2r, input logic [1:0] we, input logic rdwe,
                                     input logic srcb, input logic br, input logic [1:0] op,
                                     input logic r1, input logic r2, input logic pc,
                                     input logic md, input logic zb, input logic il);
    return {m2r, we, rdwe, srcb, br, op, r1, r2, pc, md, zb, il};
  endfunction

  function automatic logic [13:0] act_word();
    return {bus.mem_to_reg_o, bus.data_mem_we_o, bus.rd_we_o, bus.alu_src_b_o, bus.branch_o,
            bus.alu_2bit_op_o, bus.rs1_in_use_o, bus.rs2_in_use_o, bus.pc_operand_o,
            bus.muldiv_o, bus.zbb_o, bus.illegal_o};
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bus.instr_valid_i = v;
    bus.opcode_i      = op;
    bus.funct3_i      = f3;
    bus.funct7_i      = f7;
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic [13:0] e);
    drive(1'b1, op, f3, f7);
    exp_q.push_back(e);
    cyc();
  endtask

  localparam logic [13:0] W_ADD  = 14'b0_00_1_0_0_10_1_1_0_0_0_0;
  localparam logic [13:0] W_SH   = 14'b0_10_0_1_0_00_1_1_0_0_0_0;
  localparam logic [13:0] W_DIV  = 14'b0_00_1_0_0_10_1_1_0_1_0_0;
  localparam logic [13:0] W_ADDI = 14'b0_00_1_1_0_11_1_0_0_0_0_0;
  localparam logic [13:0] W_ILL  = 14'b0_00_0_0_0_00_0_0_0_0_0_1;

  // Monitor: EX consumes a word whenever it is valid and not stalled
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.ex_valid_o && !bus.stall_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got word 0x%0h with no expected entry", act_word());
        end else begin
          mon_exp = exp_q.pop_front();
          chkn("sb_word", 32'(act_word()), 32'(mon_exp));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 7'd0, 3'd0, 7'd0);
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    #12;
    chkn("rst_word", 32'(act_word()), 32'd0);
    chk1("rst_ex_valid", bus.ex_valid_o, 1'b0);
    chk1("rst_busy", bus.busy_o, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk1("rst_ready", bus.instr_ready_o, 1'b1);

    // ADD, then SH offered while EX stalls
    send(7'b0110011, 3'b000, 7'b0000000, W_ADD);
    chk1("add_valid", bus.ex_valid_o, 1'b1);
    chk1("add_rdwe", bus.rd_we_o, 1'b1);
    chkn("add_op", 32'(bus.alu_2bit_op_o), 32'd2);
    chk1("add_rs2", bus.rs2_in_use_o, 1'b1);
    bus.stall_i = 1'b1;
    drive(1'b1, 7'b0100011, 3'b001, 7'b0000000);
    #1;
    chk1("stall_ready", bus.instr_ready_o, 1'b0);
    cyc();
    chk1("hold_valid", bus.ex_valid_o, 1'b1);
    chkn("hold_word", 32'(act_word()), 32'(W_ADD));
    bus.stall_i = 1'b0;
    send(7'b0100011, 3'b001, 7'b0000000, W_SH);
    chkn("sh_we", 32'(bus.data_mem_we_o), 32'd2);
    drive(1'b0, 7'd0, 3'd0, 7'd0);
    cyc();
    chk1("idle_valid", bus.ex_valid_o, 1'b0);

    // Back-to-back stream across the decode table
    send(7'b0110011, 3'b000, 7'b0100000, W_ADD);
    send(7'b0110011, 3'b001, 7'b0100000, W_ILL);
    send(7'b0010011, 3'b000, 7'b0000000, W_ADDI);
`ifdef ZBB_DECODE_EN
    send(7'b0010011, 3'b001, 7'b0110000, 14'b0_00_1_1_0_11_1_0_0_0_1_0);
`else
    send(7'b0010011, 3'b001, 7'b0110000, W_ILL);
`endif
    send(7'b0000011, 3'b010, 7'b0000000, 14'b1_00_1_1_0_00_1_0_0_0_0_0);
    send(7'b1100011, 3'b000, 7'b0000000, 14'b0_00_0_1_1_01_1_1_0_0_0_0);
    send(7'b0100011, 3'b010, 7'b0000000, 14'b0_11_0_1_0_00_1_1_0_0_0_0);
    send(7'b0100011, 3'b011, 7'b0000000, W_ILL);
    send(7'b1100111, 3'b000, 7'b0000000, 14'b0_00_1_1_1_00_1_0_1_0_0_0);
    send(7'b0010111, 3'b000, 7'b0000000, 14'b0_00_1_1_0_00_0_0_1_0_0_0);
    send(7'b0110111, 3'b000, 7'b0000000, 14'b0_00_1_1_0_00_0_0_0_0_0_0);
    send(7'b1111111, 3'b000, 7'b0000000, W_ILL);
    chk1("ill_op_illegal", bus.illegal_o, 1'b1);
    chk1("ill_op_rdwe", bus.rd_we_o, 1'b0);
    chkn("ill_op_we", 32'(bus.data_mem_we_o), 32'd0);
`ifdef ZBB_DECODE_EN
    send(7'b0110011, 3'b000, 7'b0000101, 14'b0_00_1_0_0_10_1_1_0_0_1_0);
    chk1("minmax_zbb", bus.zbb_o, 1'b1);
    chk1("minmax_illegal", bus.illegal_o, 1'b0);
`else
    send(7'b0110011, 3'b000, 7'b0000101, W_ILL);
    chk1("minmax_illegal", bus.illegal_o, 1'b1);
    chk1("minmax_rdwe", bus.rd_we_o, 1'b0);
`endif
    drive(1'b0, 7'd0, 3'd0, 7'd0);
    cyc();

    // DIV: 33 busy cycles, stall ignored during the countdown
    send(7'b0110011, 3'b100, 7'b0000001, W_DIV);
    drive(1'b0, 7'd0, 3'd0, 7'd0);
    bus.stall_i = 1'b1;
    edges = 0;
    busy_n = 0;
    rdy_seen = 1'b0;
    while (!bus.ex_valid_o && edges < 60) begin
      if (bus.busy_o) busy_n++;
      if (bus.instr_ready_o) rdy_seen = 1'b1;
      cyc();
      edges++;
      if (edges == 5) bus.stall_i = 1'b0;
    end
    chkn("div_latency", 32'(edges), 32'd33);
    chkn("div_busy_cycles", 32'(busy_n), 32'd33);
    chk1("div_ready_low", rdy_seen, 1'b0);
    chk1("div_muldiv", bus.muldiv_o, 1'b1);
    chk1("div_busy_done", bus.busy_o, 1'b0);
    cyc();

    // MUL killed by flush one cycle after accept
    drive(1'b1, 7'b0110011, 3'b000, 7'b0000001);
    cyc();
    chk1("mul_busy", bus.busy_o, 1'b1);
    drive(1'b0, 7'd0, 3'd0, 7'd0);
    bus.flush_i = 1'b1;
    cyc();
    bus.flush_i = 1'b0;
    chk1("flush_busy", bus.busy_o, 1'b0);
    chk1("flush_valid", bus.ex_valid_o, 1'b0);
    chk1("flush_ready", bus.instr_ready_o, 1'b1);
    send(7'b0010011, 3'b000, 7'b0000000, W_ADDI);
    chk1("post_flush_valid", bus.ex_valid_o, 1'b1);
    // Flush beats a same-cycle accept (LUI is discarded)
    drive(1'b1, 7'b0110111, 3'b000, 7'b0000000);
    bus.flush_i = 1'b1;
    cyc();
    bus.flush_i = 1'b0;
    drive(1'b0, 7'd0, 3'd0, 7'd0);
    chk1("flush_accept_valid", bus.ex_valid_o, 1'b0);
    chkn("flush_hold_op", 32'(bus.alu_2bit_op_o), 32'd3);

    // Asynchronous reset in the middle of a DIV countdown (counter = 10)
    drive(1'b1, 7'b0110011, 3'b101, 7'b0000001);
    cyc();
    drive(1'b0, 7'd0, 3'd0, 7'd0);
    repeat (22) cyc();
    chk1("mid_div_busy", bus.busy_o, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chkn("mid_rst_word", 32'(act_word()), 32'd0);
    chk1("mid_rst_busy", bus.busy_o, 1'b0);
    chk1("mid_rst_valid", bus.ex_valid_o, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk1("mid_rst_ready", bus.instr_ready_o, 1'b1);
    repeat (12) cyc();
    chk1("mid_rst_no_stale", bus.ex_valid_o, 1'b0);

    repeat (3) cyc();
    chkn("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
- Registered successor of the ID-stage control decoder: decodes RV32IM (plus optional Zbb) control fields and holds them in an ID/EX control register.
- Adds a valid/ready handshake, downstream stall, flush, illegal-instruction detection and a multi-cycle M-extension busy counter that throttles issue.
- Sits between the instruction-fetch/ID register and the EX stage datapath muxes.

Parameters:
- MUL_CYCLES, 2, EX occupancy in cycles for MUL/MULH/MULHSU/MULHU (funct3[2]=0); legal range 1..255.
- DIV_CYCLES, 33, EX occupancy in cycles for DIV/DIVU/REM/REMU (funct3[2]=1); legal range 1..255.

Ports:
- clk in 1: single clock, rising edge.
- reset in 1: asynchronous, active-high reset.
- instr_valid_i in 1: decode fields valid.
- instr_ready_o out 1: stage can accept.
- opcode_i in 7: instruction [6:0].
- funct3_i in 3: instruction [14:12].
- funct7_i in 7: instruction [31:25].
- stall_i in 1: EX cannot take the current control word.
- flush_i in 1: kill the held control word and any in-progress mul/div.
- ex_valid_o out 1: control word valid for EX.
- mem_to_reg_o out 1: registered control field.
- data_mem_we_o out 2: 00 none, 01 SB, 10 SH, 11 SW.
- rd_we_o out 1: registered control field.
- alu_src_b_o out 1: registered control field.
- branch_o out 1: registered control field.
- alu_2bit_op_o out 2: registered control field.
- rs1_in_use_o out 1: registered control field.
- rs2_in_use_o out 1: registered control field.
- pc_operand_o out 1: registered control field.
- muldiv_o out 1: held word is an M-extension op.
- zbb_o out 1: held word is a Zbb op.
- illegal_o out 1: held word is not a recognised opcode/funct7 combination.
- busy_o out 1: mul/div countdown active.

Behaviour:
- Reset (asynchronous): all outputs 0, FSM in S_RUN, counter 0. instr_ready_o = 1 after reset release.
- Decode table (combinational, internal):
  - R 0110011: mem_to_reg 0, we 00, rd_we 1, src_b 0, branch 0, op 10, rs1/rs2 use 1/1, pc_op 0.
  - I-ALU 0010011: rd_we 1, src_b 1, op 11, rs1 use 1.
  - LOAD 0000011: mem_to_reg 1, rd_we 1, src_b 1, op 00, rs1 use 1.
  - BRANCH 1100011: branch 1, src_b 1, op 01, rs1/rs2 use 1/1.
  - STORE 0100011: src_b 1, op 00, rs1/rs2 use 1/1; we from funct3 000→01, 001→10, 010→11, others illegal with we 00.
  - JALR 1100111: rd_we 1, src_b 1, branch 1, pc_op 1, rs1 use 1.
  - AUIPC 0010111: rd_we 1, src_b 1, pc_op 1.
  - LUI 0110111: rd_we 1, src_b 1.
  - Any unlisted opcode: all fields 0, illegal 1.
- R-type legality: funct7 0000000 legal; 0100000 legal only with funct3 000 (SUB) or 101 (SRA); 0000001 legal and sets muldiv. Any other funct7 is illegal. An illegal word has rd_we 0, we 00, branch 0.
- Handshake: accept = instr_valid_i & instr_ready_o. instr_ready_o = (state==S_RUN) & (~ex_valid_o | ~stall_i). This is combinational; there is no path from instr_valid_i to instr_ready_o.
- On accept, the decoded word loads into the register next cycle. In the non-muldiv case, ex_valid_o=1 next cycle (1-cycle latency).
- Hold: while ex_valid_o & stall_i, all registered outputs are held unchanged.
- When ex_valid_o=1, stall_i=0 and there is no accept, ex_valid_o clears next cycle.
- FSM S_RUN: on accept of a muldiv word, load the word, set ex_valid_o=0 and busy_o=1, load counter with MUL_CYCLES-1 or DIV_CYCLES-1, and go to S_WAIT. If the loaded value is 0, go directly to the S_WAIT exit behaviour next cycle.
- FSM S_WAIT: counter decrements each cycle. When the counter is 0: ex_valid_o←1, busy_o←0, go to S_RUN. The stall_i input is ignored while in S_WAIT.
- Flush: registered next edge. It has priority over accept and hold. ex_valid_o←0, busy_o←0, counter←0, state←S_RUN. Any word accepted in the same cycle is discarded, and the upstream treats it as consumed.
- Fields other than ex_valid_o after a flush are don't-care but must remain deterministic (hold previous values).
- Reset mid-countdown: immediate return to reset values.

Optional Feature:
- Macro ZBB_DECODE_EN.
- When defined, these additional combinations are legal and set zbb_o=1 with R/I control fields as above:
  - R-type funct7 0100000 with funct3 111/110/100 (ANDN/ORN/XNOR).
  - R-type funct7 0000101 (MIN/MAX[U]).
  - R-type funct7 0110000 with funct3 001/101 (ROL/ROR).
  - R-type funct7 0000100 with funct3 100 (ZEXT.H).
  - I-type funct7 0110000 with funct3 001/101 (CLZ/CTZ/CPOP/SEXT/RORI).
- When undefined, all of the above are illegal and zbb_o is tied to 0.

Decomposition:
- Package ctrl_pkg: opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_BRANCH, OP_STORE, OP_JALR, OP_AUIPC, OP_LUI), funct7 constants, ALU_OP encodings, and the store-width encodings.
- One sub-module, ctrl_decode_comb: the purely combinational decode table and legality check. The top level holds the register, FSM and counter.

Test Plan:
- Reset mid-DIV countdown (counter=10) → all outputs 0 asynchronously; instr_ready_o=1 after release.
- Accept ADD (0110011/000/0000000) with stall_i=0 → next cycle ex_valid_o=1, rd_we_o=1, alu_2bit_op_o=10, rs2_in_use_o=1.
- Accept SH (0100011/001) while ex_valid_o=1 and stall_i=1 → instr_ready_o=0 and the outputs hold; one cycle after stall_i falls, data_mem_we_o=10.
- Accept DIV (funct7 0000001, funct3 100) with DIV_CYCLES=33 → busy_o=1 for 33 cycles, ex_valid_o=1 with muldiv_o=1 exactly 34 cycles after accept, instr_ready_o=0 throughout.
- MUL accepted, then flush_i at cycle 1 → busy_o=0 and ex_valid_o=0 next cycle; a following accept proceeds normally.
- Opcode 1111111, or R-type with funct7 0000101 and ZBB_DECODE_EN undefined → illegal_o=1, rd_we_o=0, data_mem_we_o=00; with the macro defined, the funct7 0000101 case gives zbb_o=1 and illegal_o=0.
